// File: rtl/ht_ltf_sched.sv
`default_nettype none
// ============================================================================
// ht_ltf_sched : sequences 1/2/4 HT-LTF symbols from a time-domain generator,
//                applying the P-matrix sign flip to symbol 1.   Rev 1.0
// ============================================================================
module ht_ltf_sched #(
  parameter int N_SAMP = 80,
  parameter int TMO    = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   n_ltf,
  input  logic         obf_en,
  input  logic [127:0] obf_coeff_a,
  input  logic [127:0] obf_coeff_b,
  input  logic         gen_started,
  input  logic [31:0]  gen_data,
  output logic         gen_letsgo,
  output logic [127:0] gen_obf_coeff,
  output logic [31:0]  ltf_data,
  output logic         ltf_valid,
  output logic         ltf_last,
  output logic         busy,
  output logic         done,
  output logic         err_timeout
);

  localparam int c_samp_w = (N_SAMP > 1) ? $clog2(N_SAMP) : 1;
  localparam int c_tmo_w  = $clog2(TMO + 1);
  localparam logic [c_samp_w-1:0] c_last_samp = c_samp_w'(N_SAMP - 1);
  localparam logic [c_tmo_w-1:0]  c_tmo_last  = c_tmo_w'(TMO - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_KICK   = 3'd1,
    S_WAIT   = 3'd2,
    S_STREAM = 3'd3,
    S_GAP    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            sym_idx_q, sym_idx_d;
  logic [c_samp_w-1:0]   samp_cnt_q, samp_cnt_d;
  logic [c_tmo_w-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic                  gap_cnt_q, gap_cnt_d;
  logic [2:0]            n_ltf_q, n_ltf_d;
  logic                  obf_en_q, obf_en_d;
  logic [127:0]          coeff_a_q, coeff_a_d;
  logic [127:0]          coeff_b_q, coeff_b_d;
  logic [31:0]           ltf_data_q, ltf_data_d;
  logic                  ltf_valid_q, ltf_last_q, ltf_last_d;
  logic                  err_q, err_d;
  logic                  capture;
  logic                  last_samp;
  logic [2:0]            sym_nxt;

  // Only 1, 2 or 4 long training symbols are legal burst lengths.
  function automatic logic [2:0] clamp_n(input logic [2:0] n);
    case (n)
      3'd0, 3'd1: clamp_n = 3'd1;
      3'd2:       clamp_n = 3'd2;
      default:    clamp_n = 3'd4;
    endcase
  endfunction

  function automatic logic [15:0] neg_sat(input logic [15:0] v);
    neg_sat = (v == 16'h8000) ? 16'h7FFF : (~v + 16'd1);
  endfunction

  always_comb begin
    state_d    = state_q;
    sym_idx_d  = sym_idx_q;
    samp_cnt_d = samp_cnt_q;
    tmo_cnt_d  = tmo_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    n_ltf_d    = n_ltf_q;
    obf_en_d   = obf_en_q;
    coeff_a_d  = coeff_a_q;
    coeff_b_d  = coeff_b_q;
    err_d      = 1'b0;
    capture    = 1'b0;
    last_samp  = 1'b0;
    sym_nxt    = sym_idx_q + 3'd1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          n_ltf_d    = clamp_n(n_ltf);
          obf_en_d   = obf_en;
          coeff_a_d  = obf_coeff_a;
          coeff_b_d  = obf_coeff_b;
          sym_idx_d  = '0;
          samp_cnt_d = '0;
          state_d    = S_KICK;
        end
      end
      S_KICK: begin
        tmo_cnt_d = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (gen_started) begin
          capture    = 1'b1;
          samp_cnt_d = c_samp_w'(1);
          state_d    = S_STREAM;
        end else if (tmo_cnt_q == c_tmo_last) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_cnt_d = tmo_cnt_q + c_tmo_w'(1);
        end
      end
      S_STREAM: begin
        capture = 1'b1;
        if (samp_cnt_q == c_last_samp) begin
          last_samp = 1'b1;
          gap_cnt_d = 1'b0;
          state_d   = S_GAP;
        end else begin
          samp_cnt_d = samp_cnt_q + c_samp_w'(1);
        end
      end
      S_GAP: begin
        // Two idle cycles let the generator fall back to idle before the next kick.
        if (gap_cnt_q) begin
          sym_idx_d = sym_nxt;
          state_d   = (sym_nxt < n_ltf_q) ? S_KICK : S_DONE;
        end else begin
          gap_cnt_d = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    gen_letsgo = (state_q == S_KICK);
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_DONE);

    gen_obf_coeff = '0;
    if (obf_en_q && (state_q == S_KICK || state_q == S_WAIT || state_q == S_STREAM)) begin
      gen_obf_coeff = sym_idx_q[0] ? coeff_b_q : coeff_a_q;
    end

    // Symbol 1 carries the -1 entry of P-matrix column [1,-1,1,1].
    ltf_data_d = '0;
    if (capture) begin
      ltf_data_d = (sym_idx_q == 3'd1) ? {neg_sat(gen_data[31:16]), neg_sat(gen_data[15:0])}
                                       : gen_data;
    end
    ltf_last_d = last_samp && (sym_nxt == n_ltf_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      sym_idx_q   <= '0;
      samp_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      gap_cnt_q   <= 1'b0;
      n_ltf_q     <= '0;
      obf_en_q    <= 1'b0;
      coeff_a_q   <= '0;
      coeff_b_q   <= '0;
      ltf_data_q  <= '0;
      ltf_valid_q <= 1'b0;
      ltf_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sym_idx_q   <= sym_idx_d;
      samp_cnt_q  <= samp_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      n_ltf_q     <= n_ltf_d;
      obf_en_q    <= obf_en_d;
      coeff_a_q   <= coeff_a_d;
      coeff_b_q   <= coeff_b_d;
      ltf_data_q  <= ltf_data_d;
      ltf_valid_q <= capture;
      ltf_last_q  <= ltf_last_d;
      err_q       <= err_d;
    end
  end

  assign ltf_data    = ltf_data_q;
  assign ltf_valid   = ltf_valid_q;
  assign ltf_last    = ltf_last_q;
  assign err_timeout = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ht_ltf_sched.sv
`default_nettype none
// ============================================================================
// tb_ht_ltf_sched : generator model plus reference scoreboard for ht_ltf_sched.
//                   Rev 1.0
// ============================================================================
module tb_ht_ltf_sched;

  localparam int c_n   = 80;
  localparam int c_tmo = 255;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   n_ltf;
  logic         obf_en;
  logic [127:0] obf_coeff_a, obf_coeff_b;
  logic         gen_started, gen_started_m, stray;
  logic [31:0]  gen_data;
  logic         gen_letsgo;
  logic [127:0] gen_obf_coeff;
  logic [31:0]  ltf_data;
  logic         ltf_valid, ltf_last, busy, done, err_timeout;

  assign gen_started = gen_started_m | stray;

  ht_ltf_sched #(.N_SAMP(c_n), .TMO(c_tmo)) dut (
    .clk(clk), .reset(reset), .start(start), .n_ltf(n_ltf), .obf_en(obf_en),
    .obf_coeff_a(obf_coeff_a), .obf_coeff_b(obf_coeff_b),
    .gen_started(gen_started), .gen_data(gen_data), .gen_letsgo(gen_letsgo),
    .gen_obf_coeff(gen_obf_coeff), .ltf_data(ltf_data), .ltf_valid(ltf_valid),
    .ltf_last(ltf_last), .busy(busy), .done(done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  // Burst context shared with the generator model (written by the tests only).
  int           burst_id = 0;
  logic         cur_obf = 1'b0;
  logic [127:0] cur_a = '0, cur_b = '0;
  bit           cur_const_en = 1'b0;
  logic [31:0]  cur_const = '0;
  int           gen_delay = 1;
  bit           gen_enable = 1'b1;
  int           n_checks = 0, n_fail = 0;

  // Generator-owned state.
  logic [31:0]  exp_mem [4096];
  int           wr = 0, coeff_bad = 0, gen_sym = 0, seen_burst = 0;

  // Monitor-owned state.
  logic [31:0]  out_log [8192];
  int cyc = 0, valid_cnt = 0, last_cnt = 0, last_at = 0, last_cyc = 0;
  int kick_cnt = 0, kick_cyc = 0, done_cnt = 0, done_cyc = 0, err_cnt = 0, err_cyc = 0;
  int busy_cyc = 0, run_bad = 0, cur_run = 0, data_bad = 0, rd = 0;

  function automatic int nsym(input logic [2:0] n);
    return (n == 3'd0) ? 1 : (n <= 3'd2) ? int'(n) : 4;
  endfunction

  function automatic logic [31:0] expect_out(input logic [31:0] raw, input int sym);
    int re, im;
    if (sym != 1) return raw;
    re = -int'($signed(raw[31:16]));
    im = -int'($signed(raw[15:0]));
    if (re > 32767) re = 32767;
    if (im > 32767) im = 32767;
    return {re[15:0], im[15:0]};
  endfunction

  function automatic logic [127:0] exp_coeff(input int sym);
    if (!cur_obf) return '0;
    return (sym % 2 == 0) ? cur_a : cur_b;
  endfunction

  function automatic logic [31:0] rand_sample();
    logic [15:0] re, im;
    re = 16'($urandom());
    im = 16'($urandom());
    if ($urandom_range(0, 7) == 0) re = 16'h8000;
    if ($urandom_range(0, 7) == 0) im = 16'h8000;
    return {re, im};
  endfunction

  // Generator model: answers each kick after gen_delay cycles with N samples.
  initial begin
    logic [31:0] raw;
    gen_started_m = 1'b0;
    gen_data      = '0;
    forever begin
      @(negedge clk);
      if (gen_letsgo && gen_enable && !reset) begin
        if (seen_burst != burst_id) begin
          seen_burst = burst_id;
          gen_sym    = 0;
        end
        for (int d = 0; d < gen_delay; d++) @(negedge clk);
        for (int i = 0; i < c_n && !reset; i++) begin
          raw           = cur_const_en ? cur_const : rand_sample();
          gen_started_m = (i == 0);
          gen_data      = raw;
          exp_mem[wr % 4096] = expect_out(raw, gen_sym);
          wr++;
          if (gen_obf_coeff !== exp_coeff(gen_sym)) coeff_bad++;
          @(negedge clk);
        end
        gen_started_m = 1'b0;
        gen_data      = $urandom();
        gen_sym++;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    cyc++;
    if (reset) begin
      rd      = wr;
      cur_run = 0;
    end else begin
      if (ltf_valid) begin
        out_log[valid_cnt % 8192] = ltf_data;
        if (rd == wr || ltf_data !== exp_mem[rd % 4096]) data_bad++;
        if (rd != wr) rd++;
        valid_cnt++;
        cur_run++;
      end else if (cur_run != 0) begin
        if (cur_run != c_n) run_bad++;
        cur_run = 0;
      end
      if (ltf_last)    begin last_cnt++; last_at = valid_cnt; last_cyc = cyc; end
      if (gen_letsgo)  begin kick_cnt++; kick_cyc = cyc; end
      if (done)        begin done_cnt++; done_cyc = cyc; end
      if (err_timeout) begin err_cnt++;  err_cyc  = cyc; end
      if (busy) busy_cyc++;
    end
  end

  task automatic do_start(input logic [2:0] n, input logic obf, input bit cst_en,
                          input logic [31:0] cst);
    @(negedge clk);
    burst_id++;
    cur_obf      = obf;
    cur_a        = {$urandom(), $urandom(), $urandom(), $urandom()};
    cur_b        = {$urandom(), $urandom(), $urandom(), $urandom()};
    cur_const_en = cst_en;
    cur_const    = cst;
    n_ltf        = n;
    obf_en       = obf;
    obf_coeff_a  = cur_a;
    obf_coeff_b  = cur_b;
    start        = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    n_ltf       = 3'($urandom());
    obf_en      = 1'($urandom());
    obf_coeff_a = {$urandom(), $urandom(), $urandom(), $urandom()};
    obf_coeff_b = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; n_ltf = 3'd2; obf_en = 1'b1;
    obf_coeff_a = '1; obf_coeff_b = '1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({gen_letsgo, ltf_valid, ltf_last, busy, done, err_timeout} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b required 000000",
        {gen_letsgo, ltf_valid, ltf_last, busy, done, err_timeout});
    end
    n_checks++;
    if ({ltf_data, gen_obf_coeff} !== 160'b0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h required 0", ltf_data, gen_obf_coeff);
    end
    start = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b required 0", busy); end
  endtask

  task automatic test_single();
    int v0 = valid_cnt, k0 = kick_cnt, d0 = done_cnt, l0 = last_cnt;
    int db0 = data_bad, cb0 = coeff_bad, rb0 = run_bad;
    bit ok;
    gen_delay = 5;
    do_start(3'd1, 1'b0, 1'b0, 32'h0);
    wait_idle(400, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL single_end: busy high after budget, required idle"); end
    n_checks++; if (kick_cnt - k0 !== 1) begin n_fail++; $display("FAIL single_kicks: got %0d required 1", kick_cnt - k0); end
    n_checks++; if (valid_cnt - v0 !== 80) begin n_fail++; $display("FAIL single_valid: got %0d required 80", valid_cnt - v0); end
    n_checks++; if (last_cnt - l0 !== 1 || last_at - v0 !== 80) begin
      n_fail++; $display("FAIL single_last: count %0d at %0d required 1 at 80", last_cnt - l0, last_at - v0); end
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL single_done: got %0d required 1", done_cnt - d0); end
    n_checks++; if (done_cyc - last_cyc !== 2) begin n_fail++; $display("FAIL single_done_lat: got %0d required 2", done_cyc - last_cyc); end
    n_checks++; if (data_bad - db0 !== 0) begin n_fail++; $display("FAIL single_data: mismatches %0d required 0", data_bad - db0); end
    n_checks++; if (coeff_bad - cb0 !== 0) begin n_fail++; $display("FAIL single_coeff: mismatches %0d required 0", coeff_bad - cb0); end
    n_checks++; if (run_bad - rb0 !== 0) begin n_fail++; $display("FAIL single_run: bad runs %0d required 0", run_bad - rb0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy: got %b required 0", busy); end
  endtask

  task automatic test_negation();
    int v0 = valid_cnt, k0 = kick_cnt, db0 = data_bad, cb0 = coeff_bad;
    bit ok;
    gen_delay = int'($urandom_range(1, 8));
    do_start(3'd2, 1'b1, 1'b1, 32'h4000_8000);
    wait_idle(600, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL neg_end: busy high after budget, required idle"); end
    n_checks++; if (kick_cnt - k0 !== 2) begin n_fail++; $display("FAIL neg_kicks: got %0d required 2", kick_cnt - k0); end
    n_checks++; if (valid_cnt - v0 !== 160) begin n_fail++; $display("FAIL neg_valid: got %0d required 160", valid_cnt - v0); end
    n_checks++; if (out_log[v0 % 8192] !== 32'h4000_8000) begin
      n_fail++; $display("FAIL neg_sym0: got %h required 40008000", out_log[v0 % 8192]); end
    n_checks++; if (out_log[(v0 + 80) % 8192] !== 32'hC000_7FFF || out_log[(v0 + 159) % 8192] !== 32'hC000_7FFF) begin
      n_fail++; $display("FAIL neg_sym1: got %h/%h required c0007fff", out_log[(v0 + 80) % 8192], out_log[(v0 + 159) % 8192]); end
    n_checks++; if (data_bad - db0 !== 0) begin n_fail++; $display("FAIL neg_data: mismatches %0d required 0", data_bad - db0); end
    n_checks++; if (coeff_bad - cb0 !== 0) begin n_fail++; $display("FAIL neg_coeff: mismatches %0d required 0", coeff_bad - cb0); end
    n_checks++; if (last_at - v0 !== 160) begin n_fail++; $display("FAIL neg_last: at %0d required 160", last_at - v0); end
  endtask

  task automatic test_clamp_and_random();
    logic [2:0] n;
    for (int it = 0; it < 8; it++) begin
      int v0 = valid_cnt, k0 = kick_cnt, d0 = done_cnt, l0 = last_cnt;
      int db0 = data_bad, cb0 = coeff_bad, rb0 = run_bad, ns;
      bit ok;
      n = (it == 0) ? 3'd0 : (it == 1) ? 3'd3 : 3'($urandom());
      ns = nsym(n);
      gen_delay = int'($urandom_range(1, 10));
      do_start(n, 1'($urandom()), 1'b0, 32'h0);
      wait_idle(1200, ok);
      n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL burst%0d_end: busy high after budget, required idle", it); end
      n_checks++; if (kick_cnt - k0 !== ns) begin n_fail++; $display("FAIL burst%0d_kicks: n_ltf=%0d got %0d required %0d", it, n, kick_cnt - k0, ns); end
      n_checks++; if (valid_cnt - v0 !== ns * c_n) begin n_fail++; $display("FAIL burst%0d_valid: got %0d required %0d", it, valid_cnt - v0, ns * c_n); end
      n_checks++; if (last_cnt - l0 !== 1 || last_at - v0 !== ns * c_n) begin
        n_fail++; $display("FAIL burst%0d_last: count %0d at %0d required 1 at %0d", it, last_cnt - l0, last_at - v0, ns * c_n); end
      n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL burst%0d_done: got %0d required 1", it, done_cnt - d0); end
      n_checks++; if (data_bad - db0 !== 0 || coeff_bad - cb0 !== 0 || run_bad - rb0 !== 0) begin
        n_fail++; $display("FAIL burst%0d_stream: data %0d coeff %0d runs %0d required 0", it, data_bad - db0, coeff_bad - cb0, run_bad - rb0); end
    end
  endtask

  task automatic test_stray_started();
    int v0 = valid_cnt, b0 = busy_cyc;
    @(negedge clk);
    stray = 1'b1;
    repeat (6) @(negedge clk);
    stray = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (valid_cnt - v0 !== 0 || busy_cyc - b0 !== 0) begin
      n_fail++; $display("FAIL stray: valid %0d busy %0d required 0/0", valid_cnt - v0, busy_cyc - b0); end
  endtask

  task automatic test_busy_start();
    int v0 = valid_cnt, k0 = kick_cnt, d0 = done_cnt, db0 = data_bad;
    bit ok;
    gen_delay = 2;
    do_start(3'd1, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 200 && valid_cnt - v0 < 20; k++) @(negedge clk);
    n_ltf = 3'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(400, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL busy_start_end: busy high after budget, required idle"); end
    n_checks++; if (kick_cnt - k0 !== 1 || valid_cnt - v0 !== 80) begin
      n_fail++; $display("FAIL busy_start: kicks %0d valid %0d required 1/80", kick_cnt - k0, valid_cnt - v0); end
    n_checks++; if (done_cnt - d0 !== 1 || data_bad - db0 !== 0) begin
      n_fail++; $display("FAIL busy_start_done: done %0d data %0d required 1/0", done_cnt - d0, data_bad - db0); end
  endtask

  task automatic test_reset_mid();
    int v0 = valid_cnt, k0, d0, db0, cb0;
    bit ok, reached = 1'b0;
    gen_delay = 3;
    do_start(3'd2, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 300; k++) begin
      if (valid_cnt - v0 >= 40) begin reached = 1'b1; break; end
      @(negedge clk);
    end
    n_checks++; if (reached !== 1'b1) begin n_fail++; $display("FAIL midrst_reach: got %0d samples required 40", valid_cnt - v0); end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({gen_letsgo, ltf_valid, ltf_last, busy, done, err_timeout} !== 6'b0) begin
      n_fail++; $display("FAIL midrst_flags: got %b required 000000",
        {gen_letsgo, ltf_valid, ltf_last, busy, done, err_timeout});
    end
    n_checks++;
    if ({ltf_data, gen_obf_coeff} !== 160'b0) begin
      n_fail++; $display("FAIL midrst_data: got %h/%h required 0", ltf_data, gen_obf_coeff);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    v0 = valid_cnt; k0 = kick_cnt; d0 = done_cnt; db0 = data_bad; cb0 = coeff_bad;
    do_start(3'd1, 1'b1, 1'b0, 32'h0);
    wait_idle(400, ok);
    n_checks++; if (ok !== 1'b1 || done_cnt - d0 !== 1) begin
      n_fail++; $display("FAIL midrst_fresh: idle %0d done %0d required 1/1", ok, done_cnt - d0); end
    n_checks++; if (kick_cnt - k0 !== 1 || valid_cnt - v0 !== 80) begin
      n_fail++; $display("FAIL midrst_fresh_cnt: kicks %0d valid %0d required 1/80", kick_cnt - k0, valid_cnt - v0); end
    n_checks++; if (data_bad - db0 !== 0 || coeff_bad - cb0 !== 0) begin
      n_fail++; $display("FAIL midrst_fresh_data: data %0d coeff %0d required 0/0", data_bad - db0, coeff_bad - cb0); end
  endtask

  task automatic test_timeout();
    int v0 = valid_cnt, d0 = done_cnt, e0 = err_cnt;
    bit ok;
    gen_enable = 1'b0;
    do_start(3'd2, 1'b0, 1'b0, 32'h0);
    wait_idle(c_tmo + 50, ok);
    repeat (3) @(negedge clk);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL tmo_end: busy high after budget, required idle"); end
    n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL tmo_pulse: got %0d pulses required 1", err_cnt - e0); end
    n_checks++; if (err_cyc - kick_cyc !== c_tmo + 1) begin
      n_fail++; $display("FAIL tmo_latency: got %0d cycles after kick required %0d", err_cyc - kick_cyc, c_tmo + 1); end
    n_checks++; if (done_cnt - d0 !== 0 || valid_cnt - v0 !== 0) begin
      n_fail++; $display("FAIL tmo_side: done %0d valid %0d required 0/0", done_cnt - d0, valid_cnt - v0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_idle: busy=%b required 0", busy); end
    gen_enable = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    stray = 1'b0;
    test_reset();
    test_single();
    test_negation();
    test_clamp_and_random();
    test_stray_started();
    test_busy_start();
    test_reset_mid();
    test_timeout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
